// File: rtl/dl_float_pkg.sv
// Shared types for the DL_float operand word stream.
package dl_float_pkg;

    // Default operand word width (fp16 / bf16).
    localparam int DATA_W = 16;

    typedef logic [DATA_W-1:0] word_t;

    // One operand pair as delivered by the upstream scheduler.
    typedef struct packed {
        word_t a;
        word_t b;
    } operand_pair_t;

    // Serializer states: IDLE has nothing on the bus, SEND_A/SEND_B present that word.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEND_A = 2'd1,
        SEND_B = 2'd2
    } tx_state_t;

endpackage

// File: rtl/pair_fifo.sv
// Synchronous FIFO holding whole operand pairs; full/empty derive from the occupancy count.
module pair_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_data = mem[rd_ptr];

    // Storage array; contents need no reset because the count gates every read.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two; count tracks occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (do_push && !do_pop) begin
                count <= count + CNT_W'(1);
            end else if (do_pop && !do_push) begin
                count <= count - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/operand_stream_tx.sv
// Buffers operand pairs and serializes each as two words (A then B, last on B).
module operand_stream_tx
    import dl_float_pkg::*;
#(
    parameter int DATA_W = dl_float_pkg::DATA_W,
    parameter int DEPTH  = 4,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] op_a,
    input  logic [DATA_W-1:0] op_b,
    output logic [DATA_W-1:0] data_out,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic [CNT_W-1:0]  count
);

    typedef struct packed {
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
    } pair_t;

    pair_t             wr_pair;
    pair_t             head;
    logic              fifo_full;
    logic              fifo_empty;
    logic              push;
    logic              pop;
    logic              xfer;

    tx_state_t         state;
    tx_state_t         state_n;
    logic [DATA_W-1:0] b_hold;
    logic [DATA_W-1:0] b_hold_n;
    logic [DATA_W-1:0] data_n;
    logic              valid_n;
    logic              last_n;

    assign in_ready = !rst && !fifo_full;
    assign push     = in_valid && in_ready;
    assign xfer     = out_valid && out_ready;
    assign wr_pair  = '{a: op_a, b: op_b};

    pair_fifo #(
        .WIDTH (2 * DATA_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push),
        .wr_data (wr_pair),
        .pop     (pop),
        .rd_data (head),
        .count   (count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // Next-state and output-register logic; a pair is popped only when its A word can be loaded.
    always_comb begin
        state_n  = state;
        data_n   = data_out;
        valid_n  = out_valid;
        last_n   = out_last;
        b_hold_n = b_hold;
        pop      = 1'b0;
        unique case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    pop      = 1'b1;
                    data_n   = head.a;
                    b_hold_n = head.b;
                    valid_n  = 1'b1;
                    last_n   = 1'b0;
                    state_n  = SEND_A;
                end
            end
            SEND_A: begin
                if (xfer) begin
                    data_n  = b_hold;
                    last_n  = 1'b1;
                    state_n = SEND_B;
                end
            end
            SEND_B: begin
                if (xfer) begin
                    if (!fifo_empty) begin
                        pop      = 1'b1;
                        data_n   = head.a;
                        b_hold_n = head.b;
                        last_n   = 1'b0;
                        state_n  = SEND_A;
                    end else begin
                        valid_n = 1'b0;
                        last_n  = 1'b0;
                        state_n = IDLE;
                    end
                end
            end
            default: begin
                valid_n = 1'b0;
                last_n  = 1'b0;
                state_n = IDLE;
            end
        endcase
    end

    // State and output registers; reset discards any word in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            data_out  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            b_hold    <= '0;
        end else begin
            state     <= state_n;
            data_out  <= data_n;
            out_valid <= valid_n;
            out_last  <= last_n;
            b_hold    <= b_hold_n;
        end
    end

endmodule

// File: doc/operand_stream_tx.md
Name: operand_stream_tx

Overview:
- Transmit end of the 16-bit operand word stream consumed by the DL_float operand register wrapper. That wrapper captures sequential data words into its A/B operand registers.
- This block accepts complete operand pairs (A, B) from the upstream scheduler over a valid/ready handshake and buffers them in a small FIFO.
- It serializes each pair as two words on a valid/ready output bus: A first, then B, with out_last marking B.

Parameters:
- DATA_W, 16, width of one operand word (fp16/bf16).
- DEPTH, 4, pair FIFO depth in pairs; must be a power of 2 and at least 2.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  upstream pair valid.
- in_ready  out  1  block can accept a pair.
- op_a  in  DATA_W  operand A of the pair.
- op_b  in  DATA_W  operand B of the pair.
- data_out  out  DATA_W  serialized operand word.
- out_valid  out  1  data_out valid.
- out_ready  in  1  downstream accepts the word.
- out_last  out  1  high when data_out carries B.
- count  out  $clog2(DEPTH+1)  pairs held in the FIFO (excludes the pair in the serializer).

Behaviour:
- Reset (rst=1 at a rising edge):
  - data_out=0, out_valid=0, out_last=0, count=0.
  - FIFO pointers cleared; B hold register cleared; FSM goes to IDLE.
  - in_ready is forced 0 while rst=1.
  - Reset mid-operation discards all buffered and in-flight words; nothing is emitted afterwards until new pairs arrive.
- Input handshake:
  - in_ready = !rst && (count != DEPTH). It is combinational from registered state and does not depend on in_valid.
  - A push occurs on an edge with in_valid && in_ready.
  - When full, input is refused even if a pop happens on the same edge.
- Output handshake:
  - A word transfers on an edge with out_valid && out_ready.
  - While out_valid=1 and no transfer has occurred, data_out and out_last must hold stable.
  - out_valid never drops without a transfer, except on reset.
- FSM states: IDLE, SEND_A, SEND_B.
  - IDLE: if the FIFO is non-empty, pop the head; data_out<=A; store B in the hold register; out_valid<=1; out_last<=0; go to SEND_A.
  - SEND_A: on transfer, data_out<=B; out_last<=1; go to SEND_B.
  - SEND_B, transfer with FIFO non-empty: pop; data_out<=next A; out_last<=0; go to SEND_A. There is no bubble between pairs.
  - SEND_B, transfer with FIFO empty: out_valid<=0; out_last<=0; data_out holds its value; go to IDLE.
- Latency:
  - Pair pushed at edge N into an empty FIFO with the FSM in IDLE: A is presented from edge N+1 (out_valid high after N+1).
  - With out_ready=1 throughout, B follows at edge N+2.
  - Steady-state throughput: 1 word/cycle, i.e. 1 pair per 2 cycles.
- Count update:
  - push only: count+1.
  - pop only: count-1.
  - push and pop on the same edge: count unchanged.
- Pointers wrap modulo DEPTH. Full/empty are derived from count.
- Width: words pass through unmodified. No arithmetic on data.

Decomposition:
- Shared package dl_float_pkg:
  - DATA_W default constant.
  - typedef word_t = logic [DATA_W-1:0].
  - struct operand_pair_t {word_t a; word_t b;}.
  - enum tx_state_t {IDLE, SEND_A, SEND_B}.
- Sub-module pair_fifo: synchronous FIFO of operand_pair_t with push, pop, rd_data, count, full, empty, and the same clk/rst.
- operand_stream_tx contains the FSM, the B hold register and the output registers.

Test Plan:
- Reset: rst=1 for 2 cycles with in_valid=1 -> in_ready=0, out_valid=0, data_out=0000, count=0. After release, in_ready=1 and nothing is pushed during reset.
- Single pair: push A=000A, B=000B at edge N with out_ready=1 -> edge N+1: data_out=000A, out_last=0. Edge N+2: data_out=000B, out_last=1. Edge N+3: out_valid=0.
- Back-to-back: push (000A,000B) then (000C,000D) on consecutive edges, out_ready=1 -> out_valid continuously high for 4 cycles, words 000A,000B,000C,000D, out_last=0,1,0,1.
- Backpressure/full: out_ready=0; push pairs (0001,0002)…(0009,000A) -> first pair is in the serializer; after 4 more pushes count=4 and in_ready=0; the sixth pair is refused; data_out stays 0001.
  - Then set out_ready=1 -> 10 words 0001..000A in order. count decrements by 1 at each A word presented.
- Simultaneous push/pop: count=2, push on the same edge the serializer pops at a SEND_B→SEND_A transition -> count stays 2 and word order is preserved.
- Mid-operation reset: assert rst for 1 cycle while in SEND_A with 2 pairs queued -> next cycle out_valid=0, count=0. No stale word appears afterwards; a new pair (1234,5678) emits 1234, 5678 normally.
